ysyx_22040210_btb_upd: RTL
==========================

YSYX_22040210_BTB_UPD -- requirements
Module: ysyx_22040210_btb_upd

Interface
REQ-001 Parameter UPD_DEPTH, default 4, SHALL set update-queue entries; legal values are powers of 2 and at least 2.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cmt_valid0_i / cmt_valid1_i  in  1 each  commit slot 0 (older) and slot 1 (younger) carry a resolved control-flow instruction.
REQ-005 cmt_pc0_i / cmt_pc1_i  in  64 each  PC of the slot instruction.
REQ-006 cmt_target0_i / cmt_target1_i  in  64 each  resolved target address.
REQ-007 cmt_op0_i / cmt_op1_i  in  3 each  jump op code, the same encoding the BTB stores.
REQ-008 cmt_taken0_i / cmt_taken1_i  in  1 each  resolved taken.
REQ-009 cmt_phit0_i / cmt_phit1_i  in  1 each  the BTB hit when this instruction was fetched.
REQ-010 cmt_ptgt0_i / cmt_ptgt1_i  in  64 each  the predicted target used at fetch.
REQ-011 cmt_ready_o  out  1  queue can accept both slots this cycle.
REQ-012 btb_fixwe_o  out  1  BTB write enable.
REQ-013 btb_fixpc_o  out  64  BTB write PC (index and tag).
REQ-014 btb_fixjumpaddr_o  out  64  BTB write target.
REQ-015 btb_fixjumpop_o  out  3  BTB write op.
REQ-016 upd_cnt_o  out  32  count of BTB writes issued, saturating at 0xFFFF_FFFF.

Function
REQ-017 A slot SHALL be accepted only when its valid, cmt_ready_o and cmt_taken are all 1; not-taken slots are never enqueued.
REQ-018 When both slots are accepted, slot 0 SHALL be enqueued before slot 1, both in the same cycle.
REQ-019 When both slots qualify with equal PC, only slot 1 SHALL be enqueued.
REQ-020 cmt_ready_o SHALL equal 1 when the registered free-entry count is at least 2; it is a function of registered state only.
REQ-021 Valid slots presented while cmt_ready_o is 0 SHALL be ignored; the queue state is unchanged by them.
REQ-022 btb_fixwe_o SHALL be 1 whenever the queue is non-empty, and btb_fixpc/jumpaddr/jumpop SHALL show the head entry.
REQ-023 The head entry SHALL be popped on every cycle btb_fixwe_o is 1; the BTB has no backpressure.
REQ-024 When btb_fixwe_o is 0, btb_fixpc_o, btb_fixjumpaddr_o and btb_fixjumpop_o SHALL be 0.
REQ-025 Latency: an entry accepted at edge N into an empty queue SHALL drive btb_fixwe_o during the cycle following edge N; there is no same-cycle bypass.
REQ-026 Pop and push in the same cycle SHALL be supported; count_next = count + pushes - pop, where pushes is 0..2 and pop is 0..1.
REQ-027 Read and write pointers SHALL wrap modulo UPD_DEPTH; the count is clog2(UPD_DEPTH)+1 bits wide and never exceeds UPD_DEPTH.
REQ-028 upd_cnt_o SHALL increment by 1 for each cycle with btb_fixwe_o equal to 1, holding at its maximum value.

Reset
REQ-029 On rst, the count, pointers and upd_cnt_o SHALL clear, giving btb_fixwe_o = 0, all fix outputs = 0 and cmt_ready_o = 1 in the cycle after reset.
REQ-030 Reset asserted while the queue is non-empty SHALL discard all entries, and no BTB write SHALL occur in the cycle after reset.

Configuration
REQ-031 Macro YSYX_22040210_BTB_UPD_FILTER_EN defined: a taken slot with cmt_phit = 1 and cmt_ptgt == cmt_target SHALL be treated as not qualifying, so it is not enqueued.
REQ-032 Macro YSYX_22040210_BTB_UPD_FILTER_EN undefined: every taken slot qualifies, and cmt_phit/cmt_ptgt are ignored.

Verification
REQ-033 After reset, slot 0 taken, pc=0x8000_0010, target=0x8000_0100, op=3 -> next cycle: fixwe=1, fixpc=0x8000_0010, fixjumpaddr=0x8000_0100, op=3; following cycle: fixwe=0 and upd_cnt_o=1.
REQ-034 Both slots taken (pc 0x80000020 and 0x80000024) every cycle with DEPTH=4 -> cmt_ready_o falls once count reaches 3; writes come out in pc order 0x20, 0x24, 0x20, ...; no entry is lost or duplicated.
REQ-035 Both slots taken with equal pc 0x80000040, targets 0xA0 and 0xB0 -> exactly one write, with fixjumpaddr=0x...B0.
REQ-036 Slot 0 not-taken and slot 1 taken -> only slot 1 is written; with valid=1 and ready=0, no count change.
REQ-037 With FILTER_EN defined: phit=1, ptgt=target=0x80000200 -> no write; ptgt=0x80000204 -> one write. With FILTER_EN undefined: both cases write.
REQ-038 Fill the queue to 3 entries, then assert rst for one cycle -> fixwe=0, cmt_ready_o=1 and upd_cnt_o=0 next cycle, and no stale entry is emitted afterwards.

Source files
------------

// File: rtl/ysyx_22040210_btb_upd.sv
// BTB update queue: buffers taken commit-slot outcomes and drains one BTB write per cycle.
// Latency: 1 cycle from accept to btb_fixwe_o. Backpressure: cmt_ready_o drops when fewer than 2 entries are free.
// Optional macro YSYX_22040210_BTB_UPD_FILTER_EN drops taken slots whose fetch-time BTB prediction was already right.
module ysyx_22040210_btb_upd #(
   parameter int UPD_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmt_valid0_i,
   input  logic        cmt_valid1_i,
   input  logic [63:0] cmt_pc0_i,
   input  logic [63:0] cmt_pc1_i,
   input  logic [63:0] cmt_target0_i,
   input  logic [63:0] cmt_target1_i,
   input  logic [2:0]  cmt_op0_i,
   input  logic [2:0]  cmt_op1_i,
   input  logic        cmt_taken0_i,
   input  logic        cmt_taken1_i,
   input  logic        cmt_phit0_i,
   input  logic        cmt_phit1_i,
   input  logic [63:0] cmt_ptgt0_i,
   input  logic [63:0] cmt_ptgt1_i,
   output logic        cmt_ready_o,
   output logic        btb_fixwe_o,
   output logic [63:0] btb_fixpc_o,
   output logic [63:0] btb_fixjumpaddr_o,
   output logic [2:0]  btb_fixjumpop_o,
   output logic [31:0] upd_cnt_o
);

   localparam int PW = $clog2(UPD_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] tgt;
      logic [2:0]  op;
   } upd_ent_t;

   upd_ent_t      mem_q [UPD_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] wr_idx1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   upd_cnt_q, upd_cnt_d;
   logic          filt0, filt1;
   logic          qual0, qual1;
   logic          push0, push1, pop;
   logic [1:0]    n_push;
   upd_ent_t      ent0, ent1, head;

`ifdef YSYX_22040210_BTB_UPD_FILTER_EN
   assign filt0 = cmt_phit0_i && (cmt_ptgt0_i == cmt_target0_i);
   assign filt1 = cmt_phit1_i && (cmt_ptgt1_i == cmt_target1_i);
`else
   logic unused_filt;
   assign unused_filt = ^{cmt_phit0_i, cmt_phit1_i, cmt_ptgt0_i, cmt_ptgt1_i};
   assign filt0 = 1'b0;
   assign filt1 = 1'b0;
`endif

   // Two free slots are always reserved so both commit slots can land in one cycle.
   assign cmt_ready_o = (cnt_q <= CW'(UPD_DEPTH - 2));

   assign qual0 = cmt_valid0_i && cmt_taken0_i && cmt_ready_o && !filt0;
   assign qual1 = cmt_valid1_i && cmt_taken1_i && cmt_ready_o && !filt1;

   // Same-PC pair: the younger slot carries the newer outcome, so it alone is kept.
   assign push1  = qual1;
   assign push0  = qual0 && !(qual1 && (cmt_pc0_i == cmt_pc1_i));
   assign pop    = (cnt_q != '0);
   assign n_push = {1'b0, push0} + {1'b0, push1};

   assign ent0    = '{pc: cmt_pc0_i, tgt: cmt_target0_i, op: cmt_op0_i};
   assign ent1    = '{pc: cmt_pc1_i, tgt: cmt_target1_i, op: cmt_op1_i};
   assign wr_idx1 = wr_ptr_q + PW'(push0);

   always_comb begin
      cnt_d     = cnt_q + CW'(n_push) - CW'(pop);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      wr_ptr_d  = wr_ptr_q + PW'(n_push);
      upd_cnt_d = upd_cnt_q;
      if (pop && (upd_cnt_q != 32'hFFFF_FFFF)) begin
         upd_cnt_d = upd_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         upd_cnt_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         upd_cnt_q <= upd_cnt_d;
      end
   end

   // Storage needs no reset: entries are only visible while the count covers them.
   always_ff @(posedge clk) begin
      if (push0) begin
         mem_q[wr_ptr_q] <= ent0;
      end
      if (push1) begin
         mem_q[wr_idx1] <= ent1;
      end
   end

   assign head              = mem_q[rd_ptr_q];
   assign btb_fixwe_o       = pop;
   assign btb_fixpc_o       = pop ? head.pc  : 64'd0;
   assign btb_fixjumpaddr_o = pop ? head.tgt : 64'd0;
   assign btb_fixjumpop_o   = pop ? head.op  : 3'd0;
   assign upd_cnt_o         = upd_cnt_q;

endmodule
